// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg
//    Shared types and defaults for the generated-network I/O sequencer slice.
//    seq_state_t       : top-level sequencer phases
//                        (LOAD, WAIT, RUN, DRAIN, DONE)
//    NN_DATA_W_DEF     : default signed data width for network words
// ----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [2:0] {
        LOAD,
        WAIT,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int NN_DATA_W_DEF = 8;

endpackage

// File: rtl/nn_out_streamer.sv
// ----------------------------------------------------------------------------
// nn_out_streamer
//    Walks a result bank from address 0 to N_OUT-1 and presents each word on a
//    valid/ready port. The bank has a one-cycle read latency and the output
//    word is registered, so a word takes two cycles from address to port.
//    A one-entry skid register absorbs the read that is already in flight when
//    the consumer stalls. Without a stall, one word is delivered per cycle.
//
//    Ports
//       i_clk      clock, all logic on posedge
//       i_rst      synchronous reset, active-high
//       i_active   streaming enabled (sequencer is draining)
//       i_clear    rewind the read address for the next inference
//       o_raddr    read address into the result bank
//       i_rdata    result bank data, valid one cycle after o_raddr
//       o_valid    output word valid
//       o_data     output word
//       o_index    bank index of o_data
//       i_ready    consumer accepts o_data
//       o_last_hs  handshake on the final index in this cycle
// ----------------------------------------------------------------------------
module nn_out_streamer
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W_DEF,
    parameter int N_OUT  = 1,
    parameter int OA_W   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_active,
    input  logic              i_clear,
    output logic [OA_W-1:0]   o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [OA_W-1:0]   o_index,
    input  logic              i_ready,
    output logic              o_last_hs
);

    localparam logic [OA_W-1:0] LAST_OUT = OA_W'(N_OUT - 1);

    logic              r_all_issued;
    logic [OA_W-1:0]   r_raddr;
    logic              r_rd_vld;
    logic [OA_W-1:0]   r_rd_idx;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_data;
    logic [OA_W-1:0]   r_skid_idx;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;
    logic [OA_W-1:0]   r_out_idx;

    logic              w_hs;
    logic              w_out_load;
    logic              w_issue;
    logic [2:0]        w_occ;

    // Words that are stored or in flight, less the one leaving this cycle.
    // Issuing only while that stays below two means the output register plus
    // the skid register can always hold whatever returns from the bank, and
    // in steady flow (one stored, one in flight, one leaving) a new read still
    // goes out every cycle.
    always_comb begin
        w_hs       = r_out_vld & i_ready;
        w_out_load = ~r_out_vld | w_hs;
        w_occ      = {2'b00, r_out_vld} + {2'b00, r_skid_vld}
                   + {2'b00, r_rd_vld} - {2'b00, w_hs};
        w_issue    = i_active & ~r_all_issued & (w_occ < 3'd2);
    end

    // Read-address walk and the return path. The address stops at the last
    // index instead of wrapping. Returning data goes straight to the output
    // register when it is free. Otherwise it parks in the skid register.
    // The skid word always drains before newer data, so order is preserved.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_all_issued <= 1'b0;
            r_raddr      <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_idx     <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_idx   <= '0;
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
        end else begin
            if (i_clear) begin
                r_all_issued <= 1'b0;
                r_raddr      <= '0;
            end else if (w_issue) begin
                if (r_raddr == LAST_OUT) begin
                    r_all_issued <= 1'b1;
                end else begin
                    r_raddr <= r_raddr + OA_W'(1);
                end
            end

            r_rd_vld <= w_issue;
            r_rd_idx <= r_raddr;

            if (w_out_load) begin
                if (r_skid_vld) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_idx   <= r_skid_idx;
                    r_skid_vld  <= r_rd_vld;
                    r_skid_data <= i_rdata;
                    r_skid_idx  <= r_rd_idx;
                end else if (r_rd_vld) begin
                    r_out_vld  <= 1'b1;
                    r_out_data <= i_rdata;
                    r_out_idx  <= r_rd_idx;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else if (r_rd_vld) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= i_rdata;
                r_skid_idx  <= r_rd_idx;
            end
        end
    end

    assign o_raddr   = r_raddr;
    assign o_valid   = r_out_vld;
    assign o_data    = r_out_data;
    assign o_index   = r_out_idx;
    assign o_last_hs = w_hs & (r_out_idx == LAST_OUT);

endmodule

// File: rtl/nn_io_sequencer.sv
// ----------------------------------------------------------------------------
// nn_io_sequencer
//    Loads N_IN signed words serially into the layer-0 input memory. Then it
//    runs an N_LAYERS request/acknowledge chain. Finally it streams N_OUT
//    results from the last layer's bank out on a valid/ready port.
//    Phases: LOAD -> WAIT -> RUN -> DRAIN -> DONE -> LOAD.
//
//    Optional feature macro: NN_ARGMAX_EN. When defined, the block adds
//    o_argmax_idx and o_argmax_vld. These report the index of the largest
//    delivered result (signed; on a tie the lower index wins).
//
//    Ports
//       i_clk          clock, all logic on posedge
//       i_rst          synchronous reset, active-high
//       i_fill         input word present on i_in_data (sampled in LOAD)
//       i_in_data      signed input word
//       o_ack_fill     all N_IN words stored
//       i_req          start inference (level)
//       o_in_we        layer-0 input memory write strobe
//       o_in_addr      layer-0 input memory write address
//       o_in_wdata     layer-0 input memory write data
//       o_layer_req    per-layer request (level)
//       i_layer_ack    per-layer done (level)
//       o_out_raddr    read address into last-layer result bank
//       i_out_rdata    result data, valid one cycle after o_out_raddr
//       o_out_valid    result word valid
//       o_out_data     result word
//       o_out_index    index of o_out_data
//       i_out_ready    consumer accepts o_out_data
//       o_ack_network  inference complete, all outputs delivered
//       o_busy         sequencer is not in LOAD
//       o_argmax_idx   (NN_ARGMAX_EN) index of largest delivered result
//       o_argmax_vld   (NN_ARGMAX_EN) o_argmax_idx is meaningful
// ----------------------------------------------------------------------------
module nn_io_sequencer
    import nn_pkg::*;
#(
    parameter int  DATA_W   = NN_DATA_W_DEF,
    parameter int  N_IN     = 3,
    parameter int  N_OUT    = 1,
    parameter int  N_LAYERS = 2,
    localparam int IA_W     = ($clog2(N_IN) > 0) ? $clog2(N_IN) : 1,
    localparam int OA_W     = ($clog2(N_OUT) > 0) ? $clog2(N_OUT) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_fill,
    input  logic [DATA_W-1:0]   i_in_data,
    output logic                o_ack_fill,
    input  logic                i_req,
    output logic                o_in_we,
    output logic [IA_W-1:0]     o_in_addr,
    output logic [DATA_W-1:0]   o_in_wdata,
    output logic [N_LAYERS-1:0] o_layer_req,
    input  logic [N_LAYERS-1:0] i_layer_ack,
    output logic [OA_W-1:0]     o_out_raddr,
    input  logic [DATA_W-1:0]   i_out_rdata,
    output logic                o_out_valid,
    output logic [DATA_W-1:0]   o_out_data,
    output logic [OA_W-1:0]     o_out_index,
    input  logic                i_out_ready,
    output logic                o_ack_network,
    output logic                o_busy
`ifdef NN_ARGMAX_EN
    ,
    output logic [OA_W-1:0]     o_argmax_idx,
    output logic                o_argmax_vld
`endif
);

    localparam logic [IA_W-1:0] LAST_IN = IA_W'(N_IN - 1);

    seq_state_t            r_state;
    seq_state_t            w_next_state;
    logic [IA_W-1:0]       r_load_cnt;
    logic                  r_in_we;
    logic [IA_W-1:0]       r_in_addr;
    logic [DATA_W-1:0]     r_in_wdata;
    logic                  r_ack_fill;
    logic [N_LAYERS-1:0]   r_layer_req;
    logic                  r_ack_network;

    logic                  w_load_word;
    logic                  w_load_last;
    logic                  w_start;
    logic                  w_chain_done;
    logic                  w_drain;
    logic                  w_exit;
    logic                  w_last_hs;
    logic                  w_out_valid;
    logic [DATA_W-1:0]     w_out_data;
    logic [OA_W-1:0]       w_out_index;

    // Phase events shared by the FSM and the datapath. The last layer's
    // acknowledge only counts once its own request is up. An early or stray
    // ack cannot skip the chain.
    always_comb begin
        w_load_word  = (r_state == LOAD) & i_fill;
        w_load_last  = w_load_word & (r_load_cnt == LAST_IN);
        w_start      = (r_state == WAIT) & i_req;
        w_chain_done = (r_state == RUN) & i_layer_ack[N_LAYERS-1]
                     & r_layer_req[N_LAYERS-1];
        w_drain      = (r_state == DRAIN);
        w_exit       = (r_state == DONE) & ~i_req;
    end

    // State register. Reset wins from any phase on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-phase decision. A req seen while still loading is deliberately not
    // remembered. Only req as seen in WAIT starts the chain. Leaving DONE waits
    // for req to fall, so one held req cannot launch a second inference.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_load_last)  w_next_state = WAIT;
            WAIT:    if (w_start)      w_next_state = RUN;
            RUN:     if (w_chain_done) w_next_state = DRAIN;
            DRAIN:   if (w_last_hs)    w_next_state = DONE;
            DONE:    if (w_exit)       w_next_state = LOAD;
            default: w_next_state = LOAD;
        endcase
    end

    // Input write port, load counter and the handshake flags. Each accepted
    // word appears on the write port one cycle later. The counter parks on the
    // last address instead of wrapping and is only rewound on the way out of
    // DONE. Requests ripple one layer per acknowledge and stay raised until
    // the whole inference has been handed back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_load_cnt    <= '0;
            r_in_we       <= 1'b0;
            r_in_addr     <= '0;
            r_in_wdata    <= '0;
            r_ack_fill    <= 1'b0;
            r_layer_req   <= '0;
            r_ack_network <= 1'b0;
        end else begin
            r_in_we <= w_load_word;
            if (w_load_word) begin
                r_in_addr  <= r_load_cnt;
                r_in_wdata <= i_in_data;
                if (!w_load_last) begin
                    r_load_cnt <= r_load_cnt + IA_W'(1);
                end
            end
            if (w_load_last) begin
                r_ack_fill <= 1'b1;
            end

            if (w_start) begin
                r_layer_req[0] <= 1'b1;
            end
            if (r_state == RUN) begin
                for (int k = 0; k < N_LAYERS - 1; k++) begin
                    if (i_layer_ack[k] && r_layer_req[k]) begin
                        r_layer_req[k+1] <= 1'b1;
                    end
                end
            end

            if (w_drain && w_last_hs) begin
                r_ack_network <= 1'b1;
            end

            if (w_exit) begin
                r_load_cnt    <= '0;
                r_ack_fill    <= 1'b0;
                r_layer_req   <= '0;
                r_ack_network <= 1'b0;
            end
        end
    end

    nn_out_streamer #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT),
        .OA_W   (OA_W)
    ) u_streamer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_active  (w_drain),
        .i_clear   (w_exit),
        .o_raddr   (o_out_raddr),
        .i_rdata   (i_out_rdata),
        .o_valid   (w_out_valid),
        .o_data    (w_out_data),
        .o_index   (w_out_index),
        .i_ready   (i_out_ready),
        .o_last_hs (w_last_hs)
    );

    assign o_ack_fill    = r_ack_fill;
    assign o_in_we       = r_in_we;
    assign o_in_addr     = r_in_addr;
    assign o_in_wdata    = r_in_wdata;
    assign o_layer_req   = r_layer_req;
    assign o_out_valid   = w_out_valid;
    assign o_out_data    = w_out_data;
    assign o_out_index   = w_out_index;
    assign o_ack_network = r_ack_network;
    assign o_busy        = (r_state != LOAD);

`ifdef NN_ARGMAX_EN
    logic signed [DATA_W-1:0] r_max;
    logic [OA_W-1:0]          r_argmax_idx;
    logic                     r_argmax_vld;
    logic                     w_out_hs;

    assign w_out_hs = w_out_valid & i_out_ready;

    // Running signed maximum over delivered words. Index 0 always arrives
    // first and seeds the maximum. After that, only a strictly larger word
    // replaces it, so ties keep the earlier (lower) index. The result is
    // flagged valid for the whole of DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_max        <= '0;
            r_argmax_idx <= '0;
            r_argmax_vld <= 1'b0;
        end else begin
            if (w_out_hs && ((w_out_index == '0) || ($signed(w_out_data) > r_max))) begin
                r_max        <= $signed(w_out_data);
                r_argmax_idx <= w_out_index;
            end
            if (w_drain && w_last_hs) begin
                r_argmax_vld <= 1'b1;
            end
            if (w_exit) begin
                r_argmax_vld <= 1'b0;
            end
        end
    end

    assign o_argmax_idx = r_argmax_idx;
    assign o_argmax_vld = r_argmax_vld;
`endif

endmodule

// File: tb/tb_nn_io_sequencer.sv
// ----------------------------------------------------------------------------
// tb_nn_io_sequencer
//    Directed bench for nn_io_sequencer. Instance A uses N_IN=3, N_LAYERS=2,
//    N_OUT=1. Instance B uses N_IN=3, N_LAYERS=2, N_OUT=4. Each instance has a
//    small synchronous-read result bank. Inputs change and outputs are
//    sampled 1 time unit after each rising edge. With NN_ARGMAX_EN defined,
//    the argmax outputs are exercised as well.
// ----------------------------------------------------------------------------
module tb_nn_io_sequencer;

    logic       clk;
    logic       rst;

    logic       a_fill, a_req, a_out_ready;
    logic [7:0] a_in_data;
    logic [1:0] a_layer_ack;
    logic       a_ack_fill, a_in_we, a_out_valid, a_ack_network, a_busy;
    logic [1:0] a_in_addr;
    logic [7:0] a_in_wdata, a_out_rdata, a_out_data;
    logic [1:0] a_layer_req;
    logic [0:0] a_out_raddr, a_out_index;

    logic       b_fill, b_req, b_out_ready;
    logic [7:0] b_in_data;
    logic [1:0] b_layer_ack;
    logic       b_ack_fill, b_in_we, b_out_valid, b_ack_network, b_busy;
    logic [1:0] b_in_addr;
    logic [7:0] b_in_wdata, b_out_rdata, b_out_data;
    logic [1:0] b_layer_req;
    logic [1:0] b_out_raddr, b_out_index;

`ifdef NN_ARGMAX_EN
    logic [0:0] a_argmax_idx;
    logic       a_argmax_vld;
    logic [1:0] b_argmax_idx;
    logic       b_argmax_vld;
`endif

    logic [7:0] a_mem [0:0];
    logic [7:0] b_mem [0:3];

    int checks = 0;
    int errors = 0;

    nn_io_sequencer #(.DATA_W(8), .N_IN(3), .N_OUT(1), .N_LAYERS(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_fill(a_fill), .i_in_data(a_in_data),
        .o_ack_fill(a_ack_fill), .i_req(a_req), .o_in_we(a_in_we),
        .o_in_addr(a_in_addr), .o_in_wdata(a_in_wdata), .o_layer_req(a_layer_req),
        .i_layer_ack(a_layer_ack), .o_out_raddr(a_out_raddr), .i_out_rdata(a_out_rdata),
        .o_out_valid(a_out_valid), .o_out_data(a_out_data), .o_out_index(a_out_index),
        .i_out_ready(a_out_ready), .o_ack_network(a_ack_network), .o_busy(a_busy)
`ifdef NN_ARGMAX_EN
        , .o_argmax_idx(a_argmax_idx), .o_argmax_vld(a_argmax_vld)
`endif
    );

    nn_io_sequencer #(.DATA_W(8), .N_IN(3), .N_OUT(4), .N_LAYERS(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_fill(b_fill), .i_in_data(b_in_data),
        .o_ack_fill(b_ack_fill), .i_req(b_req), .o_in_we(b_in_we),
        .o_in_addr(b_in_addr), .o_in_wdata(b_in_wdata), .o_layer_req(b_layer_req),
        .i_layer_ack(b_layer_ack), .o_out_raddr(b_out_raddr), .i_out_rdata(b_out_rdata),
        .o_out_valid(b_out_valid), .o_out_data(b_out_data), .o_out_index(b_out_index),
        .i_out_ready(b_out_ready), .o_ack_network(b_ack_network), .o_busy(b_busy)
`ifdef NN_ARGMAX_EN
        , .o_argmax_idx(b_argmax_idx), .o_argmax_vld(b_argmax_vld)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result banks with one cycle of read latency.
    always @(posedge clk) begin
        a_out_rdata <= a_mem[a_out_raddr];
        b_out_rdata <= b_mem[b_out_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_fill = 0; a_req = 0; a_out_ready = 0; a_in_data = 0; a_layer_ack = 0;
        b_fill = 0; b_req = 0; b_out_ready = 0; b_in_data = 0; b_layer_ack = 0;
        tick();
        tick();
        checks++; if (a_ack_fill !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack_fill got %0b want 0", a_ack_fill); end
        checks++; if (a_in_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_we got %0b want 0", a_in_we); end
        checks++; if (a_in_addr !== 2'd0) begin errors++; $display("[TB] FAIL rst_in_addr got %0d want 0", a_in_addr); end
        checks++; if (a_layer_req !== 2'b00) begin errors++; $display("[TB] FAIL rst_layer_req got %b want 00", a_layer_req); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %0b want 0", a_out_valid); end
        checks++; if (a_out_raddr !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_raddr got %0d want 0", a_out_raddr); end
        checks++; if (a_ack_network !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack_network got %0b want 0", a_ack_network); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %0b want 0", a_busy); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_busy got %0b want 0", b_busy); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_out_valid got %0b want 0", b_out_valid); end
        rst = 1'b0;
    endtask

    // Load 5, -3, 7 with a req pulse during LOAD and fill kept high into WAIT,
    // then run the chain (including a stray ack[1]) and drain the one result.
    task automatic test_basic_inference();
        a_mem[0] = 8'hD6;
        a_fill = 1; a_in_data = 8'd5; a_req = 1;
        tick();
        checks++; if (a_in_we !== 1'b1) begin errors++; $display("[TB] FAIL w0_we got %0b want 1", a_in_we); end
        checks++; if (a_in_addr !== 2'd0) begin errors++; $display("[TB] FAIL w0_addr got %0d want 0", a_in_addr); end
        checks++; if (a_in_wdata !== 8'd5) begin errors++; $display("[TB] FAIL w0_data got %h want 05", a_in_wdata); end
        checks++; if (a_ack_fill !== 1'b0) begin errors++; $display("[TB] FAIL w0_ack_fill got %0b want 0", a_ack_fill); end
        a_req = 0; a_in_data = 8'hFD;
        tick();
        checks++; if (a_in_we !== 1'b1) begin errors++; $display("[TB] FAIL w1_we got %0b want 1", a_in_we); end
        checks++; if (a_in_addr !== 2'd1) begin errors++; $display("[TB] FAIL w1_addr got %0d want 1", a_in_addr); end
        checks++; if (a_in_wdata !== 8'hFD) begin errors++; $display("[TB] FAIL w1_data got %h want fd", a_in_wdata); end
        a_in_data = 8'd7;
        tick();
        checks++; if (a_in_we !== 1'b1) begin errors++; $display("[TB] FAIL w2_we got %0b want 1", a_in_we); end
        checks++; if (a_in_addr !== 2'd2) begin errors++; $display("[TB] FAIL w2_addr got %0d want 2", a_in_addr); end
        checks++; if (a_in_wdata !== 8'd7) begin errors++; $display("[TB] FAIL w2_data got %h want 07", a_in_wdata); end
        checks++; if (a_ack_fill !== 1'b1) begin errors++; $display("[TB] FAIL w2_ack_fill got %0b want 1", a_ack_fill); end
        a_in_data = 8'd99;
        tick();
        checks++; if (a_in_we !== 1'b0) begin errors++; $display("[TB] FAIL wait_fill_we got %0b want 0", a_in_we); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("[TB] FAIL wait_busy got %0b want 1", a_busy); end
        checks++; if (a_layer_req !== 2'b00) begin errors++; $display("[TB] FAIL wait_no_latch got %b want 00", a_layer_req); end
        tick();
        checks++; if (a_in_we !== 1'b0) begin errors++; $display("[TB] FAIL wait_fill_we2 got %0b want 0", a_in_we); end
        checks++; if (a_layer_req !== 2'b00) begin errors++; $display("[TB] FAIL wait_no_latch2 got %b want 00", a_layer_req); end
        a_fill = 0; a_req = 1;
        tick();
        checks++; if (a_layer_req !== 2'b01) begin errors++; $display("[TB] FAIL run_req0 got %b want 01", a_layer_req); end
        a_layer_ack = 2'b10;
        tick();
        checks++; if (a_layer_req !== 2'b01) begin errors++; $display("[TB] FAIL stray_ack1 got %b want 01", a_layer_req); end
        a_layer_ack = 2'b00;
        tick();
        tick();
        a_layer_ack = 2'b01;
        tick();
        checks++; if (a_layer_req !== 2'b11) begin errors++; $display("[TB] FAIL run_req1 got %b want 11", a_layer_req); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack1_drain got %0b want 0", a_out_valid); end
        a_layer_ack = 2'b00;
        tick();
        tick();
        a_layer_ack = 2'b10; a_out_ready = 1;
        tick();
        a_layer_ack = 2'b00;
        checks++; if (a_layer_req !== 2'b11) begin errors++; $display("[TB] FAIL drain_req_held got %b want 11", a_layer_req); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_c0_valid got %0b want 0", a_out_valid); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_c1_valid got %0b want 0", a_out_valid); end
        tick();
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_c2_valid got %0b want 1", a_out_valid); end
        checks++; if (a_out_data !== 8'hD6) begin errors++; $display("[TB] FAIL drain_data got %h want d6", a_out_data); end
        checks++; if (a_out_index !== 1'b0) begin errors++; $display("[TB] FAIL drain_index got %0d want 0", a_out_index); end
        checks++; if (a_ack_network !== 1'b0) begin errors++; $display("[TB] FAIL early_ack_network got %0b want 0", a_ack_network); end
        tick();
        checks++; if (a_ack_network !== 1'b1) begin errors++; $display("[TB] FAIL done_ack_network got %0b want 1", a_ack_network); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL done_valid got %0b want 0", a_out_valid); end
        checks++; if (a_layer_req !== 2'b11) begin errors++; $display("[TB] FAIL done_req_held got %b want 11", a_layer_req); end
        tick();
        checks++; if (a_ack_network !== 1'b1) begin errors++; $display("[TB] FAIL done_hold got %0b want 1", a_ack_network); end
        checks++; if (a_ack_fill !== 1'b1) begin errors++; $display("[TB] FAIL done_ack_fill got %0b want 1", a_ack_fill); end
        a_req = 0; a_out_ready = 0;
        tick();
        checks++; if (a_ack_network !== 1'b0) begin errors++; $display("[TB] FAIL exit_ack_network got %0b want 0", a_ack_network); end
        checks++; if (a_ack_fill !== 1'b0) begin errors++; $display("[TB] FAIL exit_ack_fill got %0b want 0", a_ack_fill); end
        checks++; if (a_layer_req !== 2'b00) begin errors++; $display("[TB] FAIL exit_layer_req got %b want 00", a_layer_req); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL exit_busy got %0b want 0", a_busy); end
    endtask

    task automatic test_reset_mid_run();
        a_fill = 1; a_in_data = 8'd1;
        tick();
        a_in_data = 8'd2;
        tick();
        a_in_data = 8'd3;
        tick();
        a_fill = 0; a_req = 1;
        tick();
        checks++; if (a_layer_req !== 2'b01) begin errors++; $display("[TB] FAIL mid_run_req got %b want 01", a_layer_req); end
        rst = 1; a_req = 0;
        tick();
        checks++; if (a_layer_req !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_req got %b want 00", a_layer_req); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy got %0b want 0", a_busy); end
        checks++; if (a_ack_fill !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ack_fill got %0b want 0", a_ack_fill); end
        rst = 0;
        a_fill = 1; a_in_data = 8'h9C;
        tick();
        checks++; if (a_in_addr !== 2'd0) begin errors++; $display("[TB] FAIL reload_w0_addr got %0d want 0", a_in_addr); end
        checks++; if (a_in_wdata !== 8'h9C) begin errors++; $display("[TB] FAIL reload_w0_data got %h want 9c", a_in_wdata); end
        a_in_data = 8'd20;
        tick();
        a_in_data = 8'd30;
        tick();
        checks++; if (a_in_addr !== 2'd2) begin errors++; $display("[TB] FAIL reload_w2_addr got %0d want 2", a_in_addr); end
        checks++; if (a_in_wdata !== 8'd30) begin errors++; $display("[TB] FAIL reload_w2_data got %h want 1e", a_in_wdata); end
        checks++; if (a_ack_fill !== 1'b1) begin errors++; $display("[TB] FAIL reload_ack_fill got %0b want 1", a_ack_fill); end
        a_fill = 0; rst = 1;
        tick();
        rst = 0;
    endtask

    // Loads three words into B and runs its chain; returns on DRAIN entry.
    task automatic b_to_drain();
        b_fill = 1; b_in_data = 8'd4;
        tick();
        b_in_data = 8'd5;
        tick();
        b_in_data = 8'hF6;
        tick();
        checks++; if (b_in_we !== 1'b1 || b_in_addr !== 2'd2 || b_in_wdata !== 8'hF6 || b_ack_fill !== 1'b1)
            begin errors++; $display("[TB] FAIL b_load got we=%0b addr=%0d data=%h ack=%0b want 1 2 f6 1", b_in_we, b_in_addr, b_in_wdata, b_ack_fill); end
        b_fill = 0; b_req = 1;
        tick();
        b_layer_ack = 2'b01;
        tick();
        b_layer_ack = 2'b10;
        tick();
        b_layer_ack = 2'b00;
    endtask

    task automatic test_back_to_back();
        b_mem[0] = 8'd11; b_mem[1] = 8'hFB; b_mem[2] = 8'd100; b_mem[3] = 8'h80;
        b_out_ready = 1;
        b_to_drain();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (b_out_valid !== 1'b1 || b_out_index !== 2'(i) || b_out_data !== b_mem[i])
                begin errors++; $display("[TB] FAIL b2b_word%0d got v=%0b idx=%0d data=%h want 1 %0d %h", i, b_out_valid, b_out_index, b_out_data, i, b_mem[i]); end
            tick();
        end
        checks++; if (b_ack_network !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack_network got %0b want 1", b_ack_network); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_drop got %0b want 0", b_out_valid); end
        b_req = 0; b_out_ready = 0;
        tick();
        checks++; if (b_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_exit_busy got %0b want 0", b_busy); end
    endtask

    task automatic test_drain_backpressure();
        int exp_idx;
        logic rdy;
        b_mem[0] = 8'h21; b_mem[1] = 8'hF0; b_mem[2] = 8'h7F; b_mem[3] = 8'h00;
        b_to_drain();
        exp_idx = 0;
        for (int cyc = 0; cyc < 40 && exp_idx < 4; cyc++) begin
            rdy = (cyc % 2 == 0);
            b_out_ready = rdy;
            if (b_out_valid) begin
                checks++; if (b_out_index !== 2'(exp_idx) || b_out_data !== b_mem[exp_idx])
                    begin errors++; $display("[TB] FAIL bp_word got idx=%0d data=%h want %0d %h", b_out_index, b_out_data, exp_idx, b_mem[exp_idx]); end
                if (rdy) exp_idx++;
            end
            tick();
        end
        checks++; if (exp_idx != 4) begin errors++; $display("[TB] FAIL bp_count got %0d want 4", exp_idx); end
        checks++; if (b_ack_network !== 1'b1) begin errors++; $display("[TB] FAIL bp_ack_network got %0b want 1", b_ack_network); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop got %0b want 0", b_out_valid); end
        b_req = 0; b_out_ready = 0;
        tick();
    endtask

`ifdef NN_ARGMAX_EN
    task automatic test_argmax();
        b_mem[0] = 8'd2; b_mem[1] = 8'hF8; b_mem[2] = 8'd9; b_mem[3] = 8'd9;
        b_out_ready = 1;
        b_to_drain();
        for (int i = 0; i < 6; i++) tick();
        checks++; if (b_ack_network !== 1'b1) begin errors++; $display("[TB] FAIL am_ack_network got %0b want 1", b_ack_network); end
        checks++; if (b_argmax_vld !== 1'b1) begin errors++; $display("[TB] FAIL am_vld got %0b want 1", b_argmax_vld); end
        checks++; if (b_argmax_idx !== 2'd2) begin errors++; $display("[TB] FAIL am_idx got %0d want 2", b_argmax_idx); end
        checks++; if (a_argmax_vld !== 1'b0 || a_argmax_idx !== 1'b0) begin errors++; $display("[TB] FAIL am_a_idle got vld=%0b idx=%0d want 0 0", a_argmax_vld, a_argmax_idx); end
        b_req = 0; b_out_ready = 0;
        tick();
        checks++; if (b_argmax_vld !== 1'b0) begin errors++; $display("[TB] FAIL am_vld_clear got %0b want 0", b_argmax_vld); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_inference();
        test_reset_mid_run();
        test_back_to_back();
        test_drain_backpressure();
`ifdef NN_ARGMAX_EN
        test_argmax();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
